// File: rtl/rssi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rssi_pkg
//  Description : Shared widths, FSM state encoding and helpers for the RSSI
//                measurement / CCA controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package rssi_pkg;

    localparam int RSSI_HALF_DB_WIDTH = 11;
    localparam int DELAY_CTL_WIDTH    = 7;

    // Two-bit state code, also exported on state_dbg
    typedef logic [1:0] state_t;

    localparam state_t c_ST_FLUSH   = 2'd0;
    localparam state_t c_ST_SETTLE  = 2'd1;
    localparam state_t c_ST_MEASURE = 2'd2;

    // Limit a requested log2 window length to the supported maximum
    function automatic logic [2:0] clamp_log2(input logic [2:0] req,
                                              input logic [2:0] lim);
        return (req > lim) ? lim : req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rssi_win_avg.sv
`default_nettype none
// ============================================================================
//  Module      : rssi_win_avg
//  Description : Windowed accumulator for signed RSSI samples. Sums
//                2^avg_log2 samples, then presents the floor average and a
//                combinational completion flag in the cycle of the final
//                sample; accumulator and count restart with no gap.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                clear         - abandon any partial window (dominant)
//                sample_en     - accept sample this cycle
//                sample        - signed sample, SAMPLE_WIDTH bits
//                avg_log2      - log2 window length (<= AVG_LOG2_MAX)
//                win_done      - final sample of window accepted this cycle
//                win_avg       - window average, valid with win_done
//  Revision    : 1.0 - initial release
// ============================================================================
module rssi_win_avg #(
    parameter int SAMPLE_WIDTH = 11,
    parameter int AVG_LOG2_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    sample_en,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic [2:0]              avg_log2,
    output logic                    win_done,
    output logic [SAMPLE_WIDTH-1:0] win_avg
);
    import rssi_pkg::*;

    localparam int c_ACC_W = SAMPLE_WIDTH + AVG_LOG2_MAX;
    localparam int c_CNT_W = AVG_LOG2_MAX + 1;

    logic signed [c_ACC_W-1:0] r_acc;
    logic signed [c_ACC_W-1:0] w_acc_sum;
    logic signed [c_ACC_W-1:0] w_acc_shift;
    logic        [c_CNT_W-1:0] r_cnt;
    logic        [c_CNT_W-1:0] w_cnt_inc;
    logic        [c_CNT_W-1:0] w_win_len;

    assign w_acc_sum   = r_acc + {{AVG_LOG2_MAX{sample[SAMPLE_WIDTH-1]}}, sample};
    // Arithmetic shift gives floor toward -inf for negative sums
    assign w_acc_shift = w_acc_sum >>> avg_log2;
    assign w_cnt_inc   = r_cnt + c_CNT_W'(1);
    assign w_win_len   = c_CNT_W'(1) << avg_log2;

    assign win_done = sample_en && !clear && (w_cnt_inc == w_win_len);
    assign win_avg  = w_acc_shift[SAMPLE_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (sample_en) begin
            if (win_done) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_acc_sum;
                r_cnt <= w_cnt_inc;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rssi_cca_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : rssi_cca_ctl
//  Description : RSSI measurement path controller. Owns the delay-FIFO
//                configuration and reset, sequences FLUSH -> SETTLE ->
//                MEASURE over the rssi_half_db stream, and produces windowed
//                average RSSI plus a hysteretic CCA busy flag.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                delay_ctl_cfg         - requested FIFO delay
//                avg_log2_cfg          - requested log2 window length
//                cca_th_half_db        - signed busy threshold
//                cca_hyst_half_db      - unsigned hysteresis
//                rx_freeze             - drop incoming samples
//                rssi_half_db(_valid)  - signed sample and strobe
//                delay_ctl             - latched FIFO delay
//                fifo_delay_rstn       - FIFO reset, active-low
//                rssi_avg_half_db      - window average
//                rssi_avg_valid        - one-cycle strobe per window
//                ch_busy               - CCA busy
//                state_dbg             - FSM state code
//  Revision    : 1.0 - initial release
// ============================================================================
module rssi_cca_ctl #(
    parameter int RSSI_HALF_DB_WIDTH = rssi_pkg::RSSI_HALF_DB_WIDTH,
    parameter int DELAY_CTL_WIDTH    = rssi_pkg::DELAY_CTL_WIDTH,
    parameter int AVG_LOG2_MAX       = 4,
    parameter int FLUSH_CYCLES       = 4,
    parameter int DISCARD_SAMPLES    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DELAY_CTL_WIDTH-1:0]    delay_ctl_cfg,
    input  logic [2:0]                    avg_log2_cfg,
    input  logic [RSSI_HALF_DB_WIDTH-1:0] cca_th_half_db,
    input  logic [5:0]                    cca_hyst_half_db,
    input  logic                          rx_freeze,
    input  logic [RSSI_HALF_DB_WIDTH-1:0] rssi_half_db,
    input  logic                          rssi_half_db_valid,
    output logic [DELAY_CTL_WIDTH-1:0]    delay_ctl,
    output logic                          fifo_delay_rstn,
    output logic [RSSI_HALF_DB_WIDTH-1:0] rssi_avg_half_db,
    output logic                          rssi_avg_valid,
    output logic                          ch_busy,
    output logic [1:0]                    state_dbg
);
    import rssi_pkg::*;

    localparam int         c_W        = RSSI_HALF_DB_WIDTH;
    localparam int         c_FCNT_W   = $clog2(FLUSH_CYCLES + 1);
    localparam int         c_DCNT_W   = $clog2(DISCARD_SAMPLES + 1);
    localparam logic [2:0] c_LOG2_MAX = 3'(AVG_LOG2_MAX);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [c_FCNT_W-1:0]        r_flush_cnt;
    logic [c_DCNT_W-1:0]        r_disc_cnt;
    logic [DELAY_CTL_WIDTH-1:0] r_delay_ctl;
    logic [2:0]                 r_avg_log2;
    logic [2:0]                 w_avg_log2_req;
    logic                       w_cfg_change;
    logic                       w_sample_ok;
    logic                       w_flush_entry;
    logic                       w_win_clear;
    logic                       w_win_en;
    logic                       w_win_done;
    logic [c_W-1:0]             w_win_avg;
    logic [c_W-1:0]             r_avg;
    logic                       r_avg_valid;
    logic                       r_ch_busy;
    logic signed [c_W:0]        w_avg_ext;
    logic signed [c_W:0]        w_th_ext;
    logic signed [c_W:0]        w_th_lo;

    assign w_avg_log2_req = clamp_log2(avg_log2_cfg, c_LOG2_MAX);
    assign w_cfg_change   = (delay_ctl_cfg != r_delay_ctl) || (w_avg_log2_req != r_avg_log2);
    // A sample coincident with a config change belongs to the old setup: drop it
    assign w_sample_ok    = rssi_half_db_valid && !rx_freeze && !w_cfg_change;

    always_comb begin
        w_state_next = r_state;
        if (w_cfg_change) begin
            w_state_next = c_ST_FLUSH;
        end else begin
            case (r_state)
                c_ST_FLUSH: begin
                    if (r_flush_cnt == c_FCNT_W'(FLUSH_CYCLES - 1))
                        w_state_next = c_ST_SETTLE;
                end
                c_ST_SETTLE: begin
                    if (w_sample_ok && (r_disc_cnt == c_DCNT_W'(DISCARD_SAMPLES - 1)))
                        w_state_next = c_ST_MEASURE;
                end
                c_ST_MEASURE: w_state_next = c_ST_MEASURE;
                default:      w_state_next = c_ST_FLUSH;
            endcase
        end
    end

    // Entering (or restarting) FLUSH latches config and restarts the hold count
    assign w_flush_entry = (w_state_next == c_ST_FLUSH) &&
                           ((r_state != c_ST_FLUSH) || w_cfg_change);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_FLUSH;
            r_flush_cnt <= '0;
            r_disc_cnt  <= '0;
            r_delay_ctl <= '0;
            r_avg_log2  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_flush_entry) begin
                r_delay_ctl <= delay_ctl_cfg;
                r_avg_log2  <= w_avg_log2_req;
                r_flush_cnt <= '0;
            end else if (r_state == c_ST_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + c_FCNT_W'(1);
            end
            if (r_state != c_ST_SETTLE)
                r_disc_cnt <= '0;
            else if (w_sample_ok)
                r_disc_cnt <= r_disc_cnt + c_DCNT_W'(1);
        end
    end

    // Window is held empty outside MEASURE and abandoned on any config change
    assign w_win_clear = (r_state != c_ST_MEASURE) || w_cfg_change;
    assign w_win_en    = (r_state == c_ST_MEASURE) && w_sample_ok;

    rssi_win_avg #(
        .SAMPLE_WIDTH (c_W),
        .AVG_LOG2_MAX (AVG_LOG2_MAX)
    ) u_win_avg (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_win_clear),
        .sample_en (w_win_en),
        .sample    (rssi_half_db),
        .avg_log2  (r_avg_log2),
        .win_done  (w_win_done),
        .win_avg   (w_win_avg)
    );

    // Hysteresis compares one bit wider so th - hyst cannot wrap
    assign w_avg_ext = {w_win_avg[c_W-1], w_win_avg};
    assign w_th_ext  = {cca_th_half_db[c_W-1], cca_th_half_db};
    assign w_th_lo   = w_th_ext - {{(c_W - 5){1'b0}}, cca_hyst_half_db};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
            r_ch_busy   <= 1'b1;
        end else begin
            r_avg_valid <= w_win_done;
            if (w_win_done) begin
                r_avg <= w_win_avg;
                if (!r_ch_busy && (w_avg_ext >= w_th_ext))
                    r_ch_busy <= 1'b1;
                else if (r_ch_busy && (w_avg_ext < w_th_lo))
                    r_ch_busy <= 1'b0;
            end
        end
    end

    assign delay_ctl        = r_delay_ctl;
    assign fifo_delay_rstn  = (r_state == c_ST_SETTLE) || (r_state == c_ST_MEASURE);
    assign rssi_avg_half_db = r_avg;
    assign rssi_avg_valid   = r_avg_valid;
    assign ch_busy          = r_ch_busy;
    assign state_dbg        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_rssi_cca_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rssi_cca_ctl
//  Description : Self-checking bench for rssi_cca_ctl: directed window
//                vectors from a table plus hand sequences for flush,
//                config change, window clamp, rx_freeze and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rssi_cca_ctl;

    localparam int W = 11;

    logic         clk = 1'b0;
    logic         rst;
    logic [6:0]   delay_ctl_cfg;
    logic [2:0]   avg_log2_cfg;
    logic [W-1:0] cca_th_half_db;
    logic [5:0]   cca_hyst_half_db;
    logic         rx_freeze;
    logic [W-1:0] rssi_half_db;
    logic         rssi_half_db_valid;
    logic [6:0]   delay_ctl;
    logic         fifo_delay_rstn;
    logic [W-1:0] rssi_avg_half_db;
    logic         rssi_avg_valid;
    logic         ch_busy;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rssi_cca_ctl dut (
        .clk                (clk),
        .rst                (rst),
        .delay_ctl_cfg      (delay_ctl_cfg),
        .avg_log2_cfg       (avg_log2_cfg),
        .cca_th_half_db     (cca_th_half_db),
        .cca_hyst_half_db   (cca_hyst_half_db),
        .rx_freeze          (rx_freeze),
        .rssi_half_db       (rssi_half_db),
        .rssi_half_db_valid (rssi_half_db_valid),
        .delay_ctl          (delay_ctl),
        .fifo_delay_rstn    (fifo_delay_rstn),
        .rssi_avg_half_db   (rssi_avg_half_db),
        .rssi_avg_valid     (rssi_avg_valid),
        .ch_busy            (ch_busy),
        .state_dbg          (state_dbg)
    );

    typedef struct packed {
        int   s0;
        int   s1;
        int   s2;
        int   s3;
        int   exp_avg;
        logic exp_busy;
    } win_vec_t;

    win_vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int v, input logic fr);
        rssi_half_db       = v[W-1:0];
        rssi_half_db_valid = 1'b1;
        rx_freeze          = fr;
        tick();
    endtask

    function automatic int pick(input win_vec_t v, input int j);
        case (j)
            0:       return v.s0;
            1:       return v.s1;
            2:       return v.s2;
            default: return v.s3;
        endcase
    endfunction

    function automatic int avg_now();
        return int'($signed(rssi_avg_half_db));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int flush_lo, settle_n, meas_n, strobes, lo, st, nf, last_avg;
        int neg_vals [4];
        int frozen;

        // th = -120, hyst = 6; all table windows use avg_log2 = 2
        vecs[0] = '{s0: -3,   s1: -2,   s2: -2,   s3: -2,   exp_avg: -3,   exp_busy: 1'b1};
        vecs[1] = '{s0: 5,    s1: 5,    s2: 5,    s3: 6,    exp_avg: 5,    exp_busy: 1'b1};
        vecs[2] = '{s0: -130, s1: -130, s2: -130, s3: -130, exp_avg: -130, exp_busy: 1'b0};
        vecs[3] = '{s0: -120, s1: -120, s2: -120, s3: -120, exp_avg: -120, exp_busy: 1'b1};
        vecs[4] = '{s0: -124, s1: -124, s2: -124, s3: -124, exp_avg: -124, exp_busy: 1'b1};
        vecs[5] = '{s0: -126, s1: -126, s2: -126, s3: -126, exp_avg: -126, exp_busy: 1'b1};
        vecs[6] = '{s0: -127, s1: -127, s2: -127, s3: -127, exp_avg: -127, exp_busy: 1'b0};
        vecs[7] = '{s0: -131, s1: -130, s2: -129, s3: -128, exp_avg: -130, exp_busy: 1'b0};

        rst                = 1'b1;
        delay_ctl_cfg      = 7'd10;
        avg_log2_cfg       = 3'd2;
        cca_th_half_db     = W'(-120);
        cca_hyst_half_db   = 6'd6;
        rx_freeze          = 1'b0;
        rssi_half_db       = W'(-100);
        rssi_half_db_valid = 1'b1;
        repeat (3) tick();

        chk("reset_delay_ctl", int'(delay_ctl), 0);
        chk("reset_fifo_rstn", int'(fifo_delay_rstn), 0);
        chk("reset_avg", avg_now(), 0);
        chk("reset_avg_valid", int'(rssi_avg_valid), 0);
        chk("reset_ch_busy", int'(ch_busy), 1);
        chk("reset_state", int'(state_dbg), 0);

        // Valid every cycle at -100 from reset release
        rst      = 1'b0;
        flush_lo = 0;
        settle_n = 0;
        meas_n   = 0;
        strobes  = 0;
        for (int cyc = 0; cyc < 60 && strobes < 3; cyc++) begin
            if (state_dbg == 2'd1) settle_n++;
            if (state_dbg == 2'd2) meas_n++;
            tick();
            if (!fifo_delay_rstn && delay_ctl == 7'd10) flush_lo++;
            if (rssi_avg_valid) begin
                strobes++;
                chk("t1_avg", avg_now(), -100);
                chk("t1_busy", int'(ch_busy), 1);
                chk("t1_window_samples", meas_n, 4 * strobes);
            end
        end
        rssi_half_db_valid = 1'b0;
        chk("t1_strobes", strobes, 3);
        chk("t1_flush_low_cycles", flush_lo, 4);
        chk("t1_discarded", settle_n, 2);
        chk("t1_delay_ctl", int'(delay_ctl), 10);

        // Table-driven windows, aligned to a window boundary
        for (int i = 0; i < 8; i++) begin
            st = 0;
            for (int j = 0; j < 4; j++) begin
                drive(pick(vecs[i], j), 1'b0);
                if (j < 3 && rssi_avg_valid) st++;
            end
            rssi_half_db_valid = 1'b0;
            chk("tbl_early_strobe", st, 0);
            chk("tbl_strobe", int'(rssi_avg_valid), 1);
            chk("tbl_avg", avg_now(), vecs[i].exp_avg);
            chk("tbl_busy", int'(ch_busy), int'(vecs[i].exp_busy));
            tick();
            chk("tbl_strobe_one_cycle", int'(rssi_avg_valid), 0);
        end

        // Delay change after 2 of 4 samples; coincident sample dropped
        drive(-90, 1'b0);
        drive(-90, 1'b0);
        delay_ctl_cfg = 7'd20;
        drive(-90, 1'b0);
        rssi_half_db_valid = 1'b0;
        chk("t4_state_flush", int'(state_dbg), 0);
        chk("t4_delay_ctl", int'(delay_ctl), 20);
        lo = 0;
        st = 0;
        for (int k = 0; k < 20 && !fifo_delay_rstn; k++) begin
            lo++;
            if (rssi_avg_valid) st++;
            tick();
        end
        chk("t4_flush_low_cycles", lo, 4);
        chk("t4_no_strobe", st, 0);
        chk("t4_busy_held", int'(ch_busy), 0);
        chk("t4_state_settle", int'(state_dbg), 1);

        // Window length request 7 clamps to 16 samples
        avg_log2_cfg = 3'd7;
        tick();
        chk("t5_state_flush", int'(state_dbg), 0);
        for (int k = 0; k < 20 && state_dbg != 2'd1; k++) tick();
        chk("t5_state_settle", int'(state_dbg), 1);
        drive(300, 1'b0);
        drive(300, 1'b0);
        rssi_half_db_valid = 1'b0;
        chk("t5_state_measure", int'(state_dbg), 2);
        nf       = 0;
        st       = 0;
        last_avg = 0;
        for (int p = 0; p < 21; p++) begin
            frozen = (p == 3 || p == 7 || p == 8 || p == 12 || p == 19) ? 1 : 0;
            if (frozen != 0) begin
                drive(400, 1'b1);
            end else begin
                drive((nf % 2 == 0) ? -50 : -61, 1'b0);
                nf++;
            end
            if (rssi_avg_valid) begin
                st++;
                last_avg = avg_now();
            end
        end
        rssi_half_db_valid = 1'b0;
        rx_freeze          = 1'b0;
        chk("t5_strobes", st, 1);
        chk("t5_avg", last_avg, -56);
        chk("t5_busy", int'(ch_busy), 1);
        chk("t5_delay_ctl", int'(delay_ctl), 20);

        // Reset in the middle of a window
        drive(-10, 1'b0);
        drive(-10, 1'b0);
        drive(-10, 1'b0);
        rst = 1'b1;
        tick();
        chk("t6_delay_ctl", int'(delay_ctl), 0);
        chk("t6_fifo_rstn", int'(fifo_delay_rstn), 0);
        chk("t6_avg", avg_now(), 0);
        chk("t6_avg_valid", int'(rssi_avg_valid), 0);
        chk("t6_ch_busy", int'(ch_busy), 1);
        chk("t6_state", int'(state_dbg), 0);
        rst                = 1'b0;
        rssi_half_db_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rssi_cca_ctl.md
Name: rssi_cca_ctl

Overview:
Controller for the RSSI measurement path.
- Owns the gpio-status delay FIFO configuration: drives its delay_ctl and fifo_delay_rstn.
- Sequences flush, settle and measurement windows over the rssi_half_db stream.
- Produces windowed average RSSI and a hysteretic clear-channel-assessment (CCA) busy flag for the xpu.

Parameters:
RSSI_HALF_DB_WIDTH, 11, width of signed RSSI values (0.5 dB step)
DELAY_CTL_WIDTH, 7, width of FIFO delay control
AVG_LOG2_MAX, 4, maximum log2 window length (window max 16 samples)
FLUSH_CYCLES, 4, clocks fifo_delay_rstn is held low per flush
DISCARD_SAMPLES, 2, valid samples dropped after flush before measuring

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
delay_ctl_cfg  in  DELAY_CTL_WIDTH  requested FIFO delay (register)
avg_log2_cfg  in  3  requested log2 window length
cca_th_half_db  in  RSSI_HALF_DB_WIDTH  signed busy threshold
cca_hyst_half_db  in  6  unsigned hysteresis
rx_freeze  in  1  pause accumulation (e.g. own TX)
rssi_half_db  in  RSSI_HALF_DB_WIDTH  signed RSSI sample
rssi_half_db_valid  in  1  sample strobe
delay_ctl  out  DELAY_CTL_WIDTH  to FIFO, latched config
fifo_delay_rstn  out  1  FIFO reset, active-low
rssi_avg_half_db  out  RSSI_HALF_DB_WIDTH  signed window average
rssi_avg_valid  out  1  one-cycle strobe per window
ch_busy  out  1  CCA busy
state_dbg  out  2  FSM state encoding

Behaviour:
Reset values:
- delay_ctl = 0, fifo_delay_rstn = 0, rssi_avg_half_db = 0, rssi_avg_valid = 0, ch_busy = 1 (conservative).
- FSM enters FLUSH; counters = 0.

Config latch:
- avg_log2 is latched as min(avg_log2_cfg, AVG_LOG2_MAX).
- Latch occurs on entry to FLUSH; delay_ctl updates in the same cycle.

FSM states, encoding in state_dbg:
- FLUSH (0): fifo_delay_rstn = 0 for exactly FLUSH_CYCLES clocks, then SETTLE. Samples are ignored.
- SETTLE (1): fifo_delay_rstn = 1. Count valid samples (ignored while rx_freeze = 1). After DISCARD_SAMPLES such samples, go to MEASURE; the next valid sample is the first one measured.
- MEASURE (2): each valid sample with rx_freeze = 0 is sign-extended into an accumulator of RSSI_HALF_DB_WIDTH+AVG_LOG2_MAX bits.
  - On the 2^avg_log2-th sample: compute avg = accumulator including that sample, arithmetic-shifted right by avg_log2 (floor toward -inf).
  - Next cycle: rssi_avg_half_db = avg, rssi_avg_valid = 1 for one cycle, ch_busy updated.
  - Accumulator and counter clear; stay in MEASURE. Back-to-back windows have no sample gap.
- Code 3 unused; if ever reached, go to FLUSH.

Config change:
- Any cycle where delay_ctl_cfg != latched delay_ctl, or the clamped avg_log2_cfg != latched value, causes the next state to be FLUSH, from any state.
- A partial window is discarded with no strobe.
- ch_busy holds its value through the flush.
- A change during FLUSH restarts the FLUSH_CYCLES count.

rx_freeze:
- Samples arriving while rx_freeze = 1 are dropped; the counter and accumulator hold.
- rx_freeze does not affect FLUSH timing.

CCA hysteresis, evaluated on window completion with signed compares at RSSI_HALF_DB_WIDTH+1 bits:
- !ch_busy and avg >= th -> ch_busy = 1.
- ch_busy and avg < th - hyst -> ch_busy = 0.
- Otherwise ch_busy holds.

Simultaneity:
- A sample arriving in the same cycle as a config change is discarded.
- rst overrides everything.

Latency: 1 clock from the completing sample's valid to rssi_avg_valid.

Decomposition:
- Shared package rssi_pkg: RSSI_HALF_DB_WIDTH, DELAY_CTL_WIDTH, 2-bit state typedef {FLUSH, SETTLE, MEASURE}.
- One natural sub-module: rssi_win_avg (accumulator, sample counter, shift, completion strobe), controlled by FSM clear/enable.

Test Plan:
1. Reset, delay_ctl_cfg = 10, avg_log2_cfg = 2, valid every cycle with rssi = -100.
   -> fifo_delay_rstn low exactly 4 clocks; first 2 samples dropped; rssi_avg_valid every 4 samples; avg = -100; delay_ctl = 10.
2. Samples -3, -2, -2, -2 with avg_log2 = 2.
   -> sum = -9, avg = -3 (floor).
   Samples 5, 5, 5, 6 -> avg = 5.
3. th = -120, hyst = 6, windows avg = -130, -120, -124, -126, -127.
   -> ch_busy = 0 after the first window (from reset 1); 1, 1, 1, 0 after the remaining windows.
4. Change delay_ctl_cfg mid-window after 2 of 4 samples.
   -> no strobe; FLUSH re-entered next cycle; fifo_delay_rstn low 4 clocks; ch_busy unchanged; new delay_ctl output.
5. avg_log2_cfg = 7.
   -> clamped to 4, 16-sample windows.
   rx_freeze high for 5 of 21 valid samples inside a window -> exactly one strobe; frozen samples excluded from the average.
6. Assert rst mid-MEASURE.
   -> next cycle all outputs at reset values, ch_busy = 1, state_dbg = 0.
